// File: rtl/posit_add_arbiter.sv
// Round-robin front end that shares one posit adder among NREQ requesters.
// Operands are registered into S1 to drive the adder, and the results are registered into S2 for a tagged response channel.
module posit_add_arbiter #(
  parameter  int N    = 8,
  parameter  int NREQ = 4,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*N-1:0]    req_in1,
  input  logic [NREQ*N-1:0]    req_in2,
  output logic [N-1:0]         add_in1,
  output logic [N-1:0]         add_in2,
  output logic                 add_start,
  input  logic [N-1:0]         add_out,
  input  logic                 add_inf,
  input  logic                 add_zero,
  input  logic                 add_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [N-1:0]         rsp_out,
  output logic                 rsp_inf,
  output logic                 rsp_zero
);

  localparam int unsigned NR = NREQ;

  logic            r_s1_valid;
  logic [N-1:0]    r_in1;
  logic [N-1:0]    r_in2;
  logic [ID_W-1:0] r_s1_id;
  logic [ID_W-1:0] r_ptr;

  logic            r_rsp_valid;
  logic [N-1:0]    r_rsp_out;
  logic            r_rsp_inf;
  logic            r_rsp_zero;
  logic [ID_W-1:0] r_rsp_id;

  logic                 w_s2_take;
  logic                 w_s1_take;
  logic [2*NREQ-1:0]    w_rot;
  logic                 w_gnt_any;
  logic [ID_W-1:0]      w_gnt_id;
  logic [ID_W-1:0]      w_ptr_nxt;
  logic [NREQ-1:0]      w_grant;
  logic [N-1:0]         w_op1;
  logic [N-1:0]         w_op2;

  assign w_s2_take = r_s1_valid & add_done & (~r_rsp_valid | rsp_ready);
  assign w_s1_take = ~r_s1_valid | w_s2_take;

  // Rotating the doubled request vector by ptr makes bit j the request at (ptr+j) mod NREQ.
  assign w_rot = {req_valid, req_valid} >> r_ptr;

  always_comb begin
    int unsigned k;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_ptr_nxt = r_ptr;
    k         = 0;
    if (w_s1_take && !rst) begin
      for (int unsigned j = 0; j < NR; j++) begin
        if (!w_gnt_any && w_rot[j]) begin
          k = 32'(r_ptr) + j;
          if (k >= NR) k = k - NR;
          w_gnt_any = 1'b1;
          w_gnt_id  = ID_W'(k);
          w_ptr_nxt = (k + 1 == NR) ? '0 : ID_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_op1   = '0;
    w_op2   = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (w_gnt_any && (w_gnt_id == ID_W'(i))) begin
        w_grant[i] = 1'b1;
        w_op1      = req_in1[i*N +: N];
        w_op2      = req_in2[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_in1      <= '0;
      r_in2      <= '0;
      r_s1_id    <= '0;
      r_ptr      <= '0;
    end else if (w_s1_take) begin
      r_s1_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_in1   <= w_op1;
        r_in2   <= w_op2;
        r_s1_id <= w_gnt_id;
        r_ptr   <= w_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_inf   <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_id    <= '0;
    end else if (w_s2_take) begin
      r_rsp_valid <= 1'b1;
      r_rsp_out   <= add_out;
      r_rsp_inf   <= add_inf;
      r_rsp_zero  <= add_zero;
      r_rsp_id    <= r_s1_id;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = w_grant;
  assign add_in1   = r_in1;
  assign add_in2   = r_in2;
  assign add_start = r_s1_valid;
  assign rsp_valid = r_rsp_valid;
  assign rsp_out   = r_rsp_out;
  assign rsp_inf   = r_rsp_inf;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Bench for posit_add_arbiter: stand-in adder (wrapping sum), per-cycle model compare, directed scenarios, random traffic.
module tb_posit_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_in1;
  logic [31:0] req_in2;
  logic [7:0]  add_in1;
  logic [7:0]  add_in2;
  logic        add_start;
  logic [7:0]  add_out;
  logic        add_inf;
  logic        add_zero;
  logic        add_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_out;
  logic        rsp_inf;
  logic        rsp_zero;
  logic        done_en;

  int checks = 0;
  int errors = 0;

  posit_add_arbiter #(.N(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_out(add_out), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero)
  );

  // Stand-in combinational adder: wrapping 8-bit sum, 0x80 flagged as inf.
  assign add_out  = add_in1 + add_in2;
  assign add_inf  = (add_out == 8'h80);
  assign add_zero = (add_out == 8'h00);
  assign add_done = done_en;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Reference model: two slots plus a rotating pointer, stepped once per cycle at negedge.
  bit m1v, m2v;
  int m1id, m1a, m1b, m2id, m2out, m2inf, m2zero, mptr;

  initial begin
    m1v = 0; m2v = 0; mptr = 0;
    m1id = 0; m1a = 0; m1b = 0; m2id = 0; m2out = 0; m2inf = 0; m2zero = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_start", 32'(add_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        m1v = 0; m2v = 0; mptr = 0;
      end else begin
        bit s2t, s1t;
        int g;
        int sum;
        logic [3:0] exp_rdy;
        chk("add_start", 32'(add_start), 32'(m1v));
        if (m1v) begin
          chk("add_in1", 32'(add_in1), 32'(m1a));
          chk("add_in2", 32'(add_in2), 32'(m1b));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m2v));
        if (m2v) begin
          chk("rsp_id", 32'(rsp_id), 32'(m2id));
          chk("rsp_out", 32'(rsp_out), 32'(m2out));
          chk("rsp_inf", 32'(rsp_inf), 32'(m2inf));
          chk("rsp_zero", 32'(rsp_zero), 32'(m2zero));
        end
        s2t = m1v && add_done && (!m2v || rsp_ready);
        s1t = !m1v || s2t;
        g = -1;
        if (s1t)
          for (int j = 0; j < 4; j++) begin
            int i;
            i = (mptr + j) % 4;
            if (g < 0 && ((req_valid >> i) & 4'd1) != 0) g = i;
          end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (s2t) begin
          sum = (m1a + m1b) % 256;
          m2v = 1; m2id = m1id; m2out = sum;
          m2inf = (sum == 128) ? 1 : 0;
          m2zero = (sum == 0) ? 1 : 0;
        end else if (m2v && rsp_ready) begin
          m2v = 0;
        end
        if (s1t) begin
          m1v = (g >= 0);
          if (g >= 0) begin
            m1id = g;
            m1a = int'((req_in1 >> (8 * g)) & 32'hFF);
            m1b = int'((req_in2 >> (8 * g)) & 32'hFF);
            mptr = (g + 1) % 4;
          end
        end
      end
    end
  end

  initial begin
    int grants, rsps, prev;
    logic [7:0] exp_ids [4];
    exp_ids[0] = 8'h01; exp_ids[1] = 8'h12; exp_ids[2] = 8'h23; exp_ids[3] = 8'h34;
    rst = 1'b1; req_valid = '0; req_in1 = '0; req_in2 = '0; rsp_ready = 1'b1; done_en = 1'b1;
    repeat (3) cyc;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_add_start", 32'(add_start), 32'd0);
    rst = 1'b0;

    // All four request together straight out of reset.
    req_valid = 4'hF; req_in1 = 32'h04030201; req_in2 = 32'h30201000;
    #1 chk("all_first_grant", 32'(req_ready), 32'h1);
    for (int e = 0; e < 5; e++) begin
      cyc;
      if (e == 3) req_valid = '0;
      if (e >= 1) begin
        chk("all_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("all_rsp_id", 32'(rsp_id), 32'(e - 1));
        chk("all_rsp_out", 32'(rsp_out), 32'(exp_ids[e-1]));
      end
    end
    req_valid = 4'hF;
    #1 chk("ptr_wrap", 32'(req_ready), 32'h1);
    req_valid = '0;

    cyc; rst = 1'b1; cyc; cyc; rst = 1'b0;

    // Single request from requester 2.
    req_valid = 4'b0100; req_in1 = 32'h00400000; req_in2 = 32'h00400000;
    cyc;
    req_valid = '0;
    chk("single_start", 32'(add_start), 32'd1);
    chk("single_in1", 32'(add_in1), 32'h40);
    chk("single_in2", 32'(add_in2), 32'h40);
    chk("single_no_rsp_yet", 32'(rsp_valid), 32'd0);
    cyc;
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_out", 32'(rsp_out), 32'h80);
    chk("single_rsp_id", 32'(rsp_id), 32'd2);
    chk("single_rsp_inf", 32'(rsp_inf), 32'd1);
    chk("single_rsp_zero", 32'(rsp_zero), 32'd0);
    cyc;
    chk("single_consumed", 32'(rsp_valid), 32'd0);

    // Backpressure: only two operations may enter.
    rsp_ready = 1'b0; req_valid = 4'hF; req_in1 = $urandom; req_in2 = $urandom;
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      #1 if (req_ready != 0) grants++;
      cyc;
    end
    chk("bp_grants", 32'(grants), 32'd2);
    #1 chk("bp_ready_zero", 32'(req_ready), 32'd0);
    req_valid = '0; rsp_ready = 1'b1;
    rsps = 0;
    for (int c = 0; c < 4; c++) begin
      #1 if (rsp_valid && rsp_ready) rsps++;
      cyc;
    end
    chk("bp_drain_count", 32'(rsps), 32'd2);

    // Fairness between requesters 0 and 3.
    req_valid = 4'b1001; prev = -1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fair_onehot", 32'((req_ready == 4'b0001) || (req_ready == 4'b1000)), 32'd1);
      if (prev >= 0) chk("fair_alternate", 32'(int'(req_ready) != prev), 32'd1);
      prev = int'(req_ready);
      cyc;
    end
    req_valid = '0;
    repeat (3) cyc;

    // add_done stall holding 0x00 + 0x00.
    done_en = 1'b0; req_valid = 4'b0010; req_in1 = '0; req_in2 = '0;
    #1 chk("stall_grant", 32'(req_ready), 32'h2);
    cyc;
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_no_grant", 32'(req_ready), 32'd0);
      chk("stall_s1_held", 32'(add_start), 32'd1);
      chk("stall_in1_held", 32'({add_in1, add_in2}), 32'd0);
      cyc;
    end
    req_valid = '0; done_en = 1'b1;
    cyc;
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_rsp_zero", 32'(rsp_zero), 32'd1);
    chk("stall_rsp_out", 32'(rsp_out), 32'd0);
    chk("stall_rsp_id", 32'(rsp_id), 32'd1);
    cyc; cyc;

    // Asynchronous reset with S1 and S2 both full.
    rsp_ready = 1'b0; req_valid = 4'hF; req_in1 = 32'h55555555; req_in2 = 32'h01010101;
    cyc; cyc;
    req_valid = '0;
    chk("pre_rst_full", 32'({add_start, rsp_valid}), 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_add_start", 32'(add_start), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_data", 32'({rsp_out, rsp_id, add_in1, add_in2}), 32'd0);
    cyc; rst = 1'b0;
    req_valid = 4'b0100; req_in1 = 32'h00110000; req_in2 = 32'h00220000; rsp_ready = 1'b1;
    cyc;
    req_valid = '0;
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    cyc;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_rsp_id", 32'(rsp_id), 32'd2);
    chk("post_rst_rsp_out", 32'(rsp_out), 32'h33);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom);
      req_in1   = $urandom;
      req_in2   = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      done_en   = ($urandom_range(0, 9) < 8);
      cyc;
    end
    req_valid = '0;
    cyc; cyc;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_add_arbiter.md
# posit_add_arbiter

Round-robin arbiter and two-stage sequencer that shares one `posit_adder` instance among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the shared adder from a registered operand stage. It captures the adder result into a registered response stage and returns it on a single tagged response channel with backpressure. It sits between the PairHMM compute lanes and the shared posit add datapath.

## Interface
- `N`, 8, posit word width; must match the attached `posit_adder`.
- `NREQ`, 4, number of requesters, 1..16.
- `ID_W`, derived: clog2(NREQ), minimum 1.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i presents an operand pair.
- `req_ready`  out  NREQ  one-hot or zero grant; transfer on `req_valid[i] & req_ready[i]`.
- `req_in1`  in  NREQ*N  operand 1, requester i at bits [i*N +: N].
- `req_in2`  in  NREQ*N  operand 2, same packing.
- `add_in1`, `add_in2`  out  N  registered operands to the shared adder.
- `add_start`  out  1  operand stage valid.
- `add_out`  in  N  adder result.
- `add_inf`, `add_zero`, `add_done`  in  1  adder flags.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  index of the originating requester.
- `rsp_out`  out  N  sum.
- `rsp_inf`, `rsp_zero`  out  1  registered adder flags.

## Operation
- **State**
  - S1 (operand stage): `s1_valid`, `add_in1`, `add_in2`, `s1_id`.
  - S2 (response stage): `rsp_valid`, `rsp_out`, `rsp_inf`, `rsp_zero`, `rsp_id`.
  - `ptr`: ID_W-bit round-robin pointer.
- **Movement conditions**
  - `s2_take = s1_valid & add_done & (!rsp_valid | rsp_ready)`
  - `s1_take = !s1_valid | s2_take`
- **Arbitration (combinational)**
  - When `s1_take` is high, scan requesters in order ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - Grant the first i with `req_valid[i]=1` by driving `req_ready[i]=1`; all other bits are 0.
  - When `s1_take` is low, `req_ready` is all 0.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not derive `req_valid` from `req_ready`.
- **On a grant to i**
  - S1 loads `req_in1[i]`, `req_in2[i]`, and id i, and sets `s1_valid`.
  - `ptr` updates to (i+1) mod NREQ.
  - `ptr` is unchanged in any cycle without a grant.
- **When `s1_take` is high with no grant:** `s1_valid` clears.
- **On `s2_take`**
  - S2 loads `add_out`, `add_inf`, `add_zero`, and `s1_id`, and sets `rsp_valid`.
- **When `rsp_valid & rsp_ready` with no `s2_take`:** `rsp_valid` clears.
- **`add_start`** equals `s1_valid`.
- **`add_done` stall:** if `add_done`=0 while `s1_valid`=1, S1 holds its operands and no new grant occurs. With a combinational adder, `add_done` mirrors `add_start`.
- **Data integrity:** operand and result bits pass through unmodified. The block performs no arithmetic.
- **Reset**
  - All registers clear asynchronously: `s1_valid`, `rsp_valid`, `add_in1`, `add_in2`, `add_start`, `rsp_out`, `rsp_id`, `rsp_inf`, `rsp_zero`, `ptr` = 0.
  - `req_ready` = 0 while `rst` is high.
  - In-flight operations are discarded without producing a response.

## Timing
- **Latency:** request accepted at edge k → `add_start`=1 during cycle k+1 → `rsp_valid`=1 during cycle k+2.
- **Throughput:** one operation per cycle while `rsp_ready`=1 and `add_done` follows `add_start`.
- **Backpressure**
  - With `rsp_ready`=0 and `rsp_valid`=1, at most 2 operations are in flight (S1 + S2).
  - In that state `req_ready` = 0, and all S1/S2 contents are held stable.
- **Simultaneous events**
  - Response handshake and new S2 load in the same cycle: S2 reloads and `rsp_valid` stays 1.
  - Grant and S1 advance in the same cycle: S1 reloads.
- **Fairness:** a continuously asserting requester is granted within NREQ grants.
- **NREQ=1:** `rsp_id` is always 0 and the pointer is constant 0.

## Test plan
- **Single request:** requester 2 sends in1=0x40, in2=0x40 (1.0+1.0, es=4, real `posit_adder`) at edge 0 → `add_start`=1 in cycle 1; `rsp_valid`=1 in cycle 2 with `rsp_out`=0x42, `rsp_id`=2, `rsp_zero`=0.
- **All requesters at once:** all 4 assert from reset with `rsp_ready`=1 → grants in order 0,1,2,3 on consecutive edges; `rsp_id` sequence 0,1,2,3 in cycles 2–5; `ptr` wraps to 0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles while all request → exactly 2 grants, `req_ready`=0 thereafter, `rsp_*` stable; release → one response per cycle, no loss or duplication.
- **Fairness wrap:** requesters 0 and 3 hold valid continuously → grants alternate 0,3,0,3; no requester is skipped.
- **`add_done` stall and zero flag:** drive `add_done`=0 for 3 cycles with S1 holding 0x00+0x00 → no grant and S1 held; then `add_done`=1 → response with `rsp_zero`=1, `rsp_out`=0x00.
- **Reset mid-operation:** assert `rst` with S1 and S2 both full → all outputs 0 immediately (asynchronous). After release, the next request yields a response exactly 2 cycles later with the correct id.
